dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder serving load/store requests from the MEM pipeline stage.
//  Supports RV32 byte/half/word accesses, alignment checking and load sign/zero extension.
//  Request and response channels use valid/ready; reads have a fixed, parameterised latency.
//  Sits between the MEM stage (initiator) and the data RAM array, which is held internally.
// PARAMETERS
//  XLEN        32    data/address width
//  DEPTH_WORDS 1024  RAM depth in XLEN-bit words; power of 2
//  LATENCY     2     read latency in cycles, accept to resp_valid; >=1
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     synchronous active-low reset
//  req_valid   in   1     request present
//  req_ready   out  1     responder can accept a request
//  req_we      in   1     1=store, 0=load
//  req_funct3  in   3     000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
//  req_addr    in   XLEN  byte address
//  req_wdata   in   XLEN  store data, right-aligned
//  resp_valid  out  1     response present
//  resp_ready  in   1     initiator accepts response
//  resp_rdata  out  XLEN  load result, extended; 0 for stores and errors
//  resp_err    out  1     misaligned access or illegal funct3
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): FSM->IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//    RAM contents are not cleared. An in-flight request is dropped and gets no response.
//  FSM states: IDLE, RWAIT, RESP.
//    IDLE: req_ready=1. Accept on req_valid&req_ready; latch addr, funct3, we.
//      Store, legal: RAM written in the accept cycle -> RESP; resp_valid at T+1, rdata=0, err=0.
//      Error: -> RESP; resp_valid at T+1, err=1, rdata=0, no RAM write.
//      Load, legal: if LATENCY==1 -> RESP, else -> RWAIT with counter=LATENCY-1.
//    RWAIT: req_ready=0; decrement counter; at 1 -> RESP. resp_valid first high at T+LATENCY.
//    RESP: req_ready=0; resp_valid=1.
//      resp_rdata and resp_err stay stable until the handshake.
//      On resp_valid&resp_ready -> IDLE; the next request is accepted no earlier than the following cycle.
//  Throughput: at most one request per LATENCY+1 cycles (store: per 2 cycles); no pipelining.
//  Indexing: word index = req_addr[$clog2(DEPTH_WORDS)+1:2]; upper bits ignored, so addresses wrap.
//  Alignment: H requires addr[0]=0; W requires addr[1:0]=00. funct3 011/110/111 is illegal.
//    For stores, funct3 100/101 is also illegal.
//  Store byte lanes: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0},+1 with wdata[15:0].
//    SW writes all 4 lanes. Unwritten lanes are preserved.
//  Load extraction: the lane is selected by the latched addr[1:0]. B/H sign-extend; BU/HU zero-extend; W as-is.
//  RAM read data is sampled when entering RESP, so a later store cannot alter a pending response.
//  Inputs are ignored when req_ready=0; req_* need only be valid in the accept cycle.
// TESTING
//  1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10
//     -> store resp at T+1, err=0; load resp_rdata=0xDEADBEEF exactly LATENCY cycles after accept.
//  2. SB 0x21 data 0x80, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LW 0x20 keeps lanes 0,2,3.
//  3. LW 0x12 and SH 0x13 -> resp_err=1, rdata=0 at T+1; a following LW 0x10 shows the RAM unchanged.
//  4. Hold resp_ready=0 for 3 cycles in RESP
//     -> resp_valid, rdata, err stable; req_ready=0; a req_valid pulse is ignored.
//  5. rst_n=0 during RWAIT -> next cycle IDLE, resp_valid=0, no response ever; earlier SW data still readable.
//  6. SW addr 0x0 data 0x1234, then LW addr DEPTH_WORDS*4 -> 0x00001234 (wrap).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: RV32 byte/half/word loads and stores
// against an internal RAM, with alignment checks and a fixed read latency.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RWAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW+1:0]   addr_q;
  logic [2:0]      f3_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            req_illegal;
  logic            req_misaligned;
  logic            req_err;
  logic [3:0]      wr_be;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   lat_idx;
  logic            unused_addr;

  assign unused_addr = ^req_addr[XLEN-1:AW+2];
  assign req_idx     = req_addr[AW+1:2];
  assign lat_idx     = addr_q[AW+1:2];
  assign accept      = (state_q == IDLE) && req_valid;

  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
      req_illegal = 1'b1;
    if (req_we && req_funct3[2])
      req_illegal = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_misaligned = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_misaligned = 1'b1;
    req_err = req_illegal || req_misaligned;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                              input logic [1:0] a,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    case (f3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = (req_err || req_we || LATENCY == 1) ? RESP : RWAIT;
      end
      RWAIT: if (cnt_q == CW'(1)) state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is captured on entry to RESP, so later stores cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr[AW+1:0];
      f3_q    <= req_funct3;
      cnt_q   <= CW'(LATENCY - 1);
      err_q   <= req_err;
      rdata_q <= (!req_err && !req_we && LATENCY == 1) ?
                 extract(mem[req_idx], req_addr[1:0], req_funct3) : '0;
    end else if (state_q == RWAIT) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1))
        rdata_q <= extract(mem[lat_idx], addr_q[1:0], f3_q);
    end else if (state_q == RESP && resp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we && !req_err) begin
      for (int unsigned i = 0; i < 4; i++)
        if (wr_be[i]) mem[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [7:0]  mm [BYTES];

  dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz = size_of(f3);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned base = a % BYTES;
    int unsigned sz = size_of(f3);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < sz; i++) v = v | (32'(mm[base + i]) << (8 * i));
    if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned base = a % BYTES;
    for (int unsigned i = 0; i < size_of(f3); i++) mm[base + i] = d[8*i +: 8];
  endtask

  // Called #1 after a clock edge with the DUT idle; returns after the response handshake.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input int unsigned hold);
    logic        e_err;
    logic [31:0] e_rd;
    int unsigned e_lat, cyc;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    e_err = model_err(we, f3, a);
    e_rd  = (e_err || we) ? 32'd0 : model_load(f3, a);
    e_lat = (e_err || we) ? 1 : LAT;
    if (we && !e_err) model_store(f3, a, d);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, e_lat);
    check("rdata", resp_rdata, e_rd);
    check("err", 32'(resp_err), 32'(e_err));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    for (int unsigned h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'($urandom_range(0, 15) * 4); req_wdata = $urandom;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, e_rd);
      check("hold_err", 32'(resp_err), 32'(e_err));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic        we;
    logic [2:0]  f3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;

    for (int unsigned w = 0; w < 16; w++) xact(1'b1, 3'd2, 32'(w * 4), $urandom, 0);

    xact(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("lw_const", model_load(3'd2, 32'h10), 32'hDEAD_BEEF);

    xact(1'b1, 3'd0, 32'h21, 32'h0000_0080, 0);
    xact(1'b0, 3'd0, 32'h21, 32'h0, 0);
    xact(1'b0, 3'd4, 32'h21, 32'h0, 0);
    xact(1'b0, 3'd2, 32'h20, 32'h0, 0);

    xact(1'b0, 3'd2, 32'h12, 32'h0, 0);
    xact(1'b1, 3'd1, 32'h13, 32'h5555_5555, 0);
    xact(1'b1, 3'd4, 32'h14, 32'h5555_5555, 0);
    xact(1'b0, 3'd7, 32'h10, 32'h0, 0);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0);

    xact(1'b0, 3'd5, 32'h22, 32'h0, 3);

    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rwait_rst_ready", 32'(req_ready), 32'd1);
    check("rwait_rst_valid", 32'(resp_valid), 32'd0);
    check("rwait_rst_rdata", resp_rdata, 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rwait_no_resp", 32'(resp_valid), 32'd0);
    end
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0);

    xact(1'b1, 3'd2, 32'h0, 32'h0000_1234, 0);
    xact(1'b0, 3'd2, 32'(BYTES), 32'h0, 0);
    check("wrap_const", model_load(3'd2, 32'(BYTES)), 32'h0000_1234);

    for (int unsigned n = 0; n < 300; n++) begin
      we = $urandom_range(0, 2) == 0;
      f3 = 3'($urandom);
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      xact(we, f3, a, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
